dual_issue_scheduler: RTL and testbench
=======================================

# dual_issue_scheduler

- Issue controller between decode and execute in the two-wide superscalar pipeline.
- Each cycle it decides whether the decoded pair (slot 1 = older, slot 2 = younger) issues together, slot 1 alone, or not at all.
- When a pair conflicts, it splits the pair across two cycles with a two-state FSM and holds fetch/decode for one cycle.
- It keeps saturating performance counters for pairing efficiency, which the bench reads alongside cycle/CPI statistics.

## Interface
- CNT_W, 32, width of each performance counter
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- valid1_i, valid2_i  in  1  decode slot holds a real instruction
- rd1_i, rs1_1_i, rs2_1_i  in  5  slot 1 destination/sources
- rd2_i, rs1_2_i, rs2_2_i  in  5  slot 2 destination/sources
- regwrite1_i, regwrite2_i  in  1  slot writes rd
- mem1_i, mem2_i  in  1  slot is load/store (single data-memory port)
- stall_i  in  1  downstream load-use stall; nothing may issue
- flush_i  in  1  execute-stage mispredict; kill decode contents
- issue1_o, issue2_o  out  1  slot advances into execute this cycle (combinational)
- hold_fd_o  out  1  freeze fetch and decode registers (combinational)
- split_o  out  1  FSM is in SPLIT2 (registered state)
- pair_cnt_o, single_cnt_o, split_cnt_o  out  CNT_W  saturating counters (registered)

## Operation
- Conflict = valid1 & valid2 & any of the following:
  - RAW: regwrite1 & rd1≠0 & (rd1==rs1_2 | rd1==rs2_2)
  - WAW: regwrite1 & regwrite2 & rd1≠0 & rd1==rd2
  - structural: mem1 & mem2
- WAR inside a pair is not a conflict; operands are read in decode.
- States: PAIR (reset), SPLIT2.
- Priority in every state: flush_i > stall_i > normal.
- PAIR:
  - flush: issue1=issue2=hold=0; stay PAIR.
  - stall: issue1=issue2=0, hold=1; stay PAIR.
  - conflict: issue1=1, issue2=0, hold=1; go to SPLIT2.
  - otherwise: issue1=valid1, issue2=valid2, hold=0; stay PAIR.
- SPLIT2 (decode still holds the same pair; slot 1 already gone):
  - flush: no issue, hold=0; go to PAIR.
  - stall: no issue, hold=1; stay SPLIT2.
  - otherwise: issue1=0, issue2=1, hold=0; go to PAIR.
- Conflict inputs are ignored in SPLIT2.
- Counters update only on cycles with no flush and no stall:
  - pair_cnt +1 when issue1 & issue2.
  - single_cnt +1 when exactly one slot issues.
  - split_cnt +1 on each PAIR→SPLIT2 transition.
  - All counters saturate at 2^CNT_W−1.
- valid2 without valid1 is legal (slot 1 bubble): issue2=1 alone, counted as single.

## Timing
- Reset (reset==0 at a rising edge):
  - state=PAIR and all counters=0 at the next edge.
  - issue outputs are forced 0 while reset is low.
  - split_o=0.
- Reset asserted while in SPLIT2 abandons the split; no issue2 follows.
- issue/hold outputs are combinational from state and same-cycle inputs; zero latency.
- A conflicting pair costs exactly one extra cycle when unstalled:
  - cycle N: issue1, hold.
  - cycle N+1: issue2.
  - new pair enters decode at cycle N+2.
- Stall cycles in SPLIT2 extend the split one cycle each; issue2 is never lost or duplicated.
- Flush and conflict in the same cycle: flush wins; state stays PAIR; split_cnt unchanged.
- Counter saturation: at max value, further increments hold the value; no wrap-around.

## Test plan
- Independent pair: add x5,x6,x7 / add x8,x9,x10, no stall → issue1=issue2=1, hold=0; after 1 cycle pair_cnt=1, split_cnt=0.
- RAW pair: rd1=x5, rs1_2=x5 → cycle N: issue1=1, issue2=0, hold=1, next split_o=1; cycle N+1: issue2=1, hold=0; split_cnt=1, single_cnt=2.
- rd1=x0 with rs1_2=x0, and mem1=mem2=0 → no conflict, dual issue. Both slots memory ops → split.
- SPLIT2 with stall_i=1 for 3 cycles → issue2=0, hold=1 each cycle; issue2=1 on the 4th cycle; split_cnt stays 1.
- Flush in SPLIT2 → issue2=0, state PAIR next cycle. Flush together with a conflicting pair in PAIR → no issue, split_o stays 0.
- Counter saturation with CNT_W=4: 20 independent pairs → pair_cnt=15. Then reset low for one edge → all counters 0, split_o=0.

Source files
------------

// File: rtl/dual_issue_scheduler.sv
// Dual-issue controller between decode and execute: decides pair/single/split issue for the
// decoded pair and keeps saturating pairing-efficiency counters.
module dual_issue_scheduler #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid1_i,
  input  logic             valid2_i,
  input  logic [4:0]       rd1_i,
  input  logic [4:0]       rs1_1_i,
  input  logic [4:0]       rs2_1_i,
  input  logic [4:0]       rd2_i,
  input  logic [4:0]       rs1_2_i,
  input  logic [4:0]       rs2_2_i,
  input  logic             regwrite1_i,
  input  logic             regwrite2_i,
  input  logic             mem1_i,
  input  logic             mem2_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             issue1_o,
  output logic             issue2_o,
  output logic             hold_fd_o,
  output logic             split_o,
  output logic [CNT_W-1:0] pair_cnt_o,
  output logic [CNT_W-1:0] single_cnt_o,
  output logic [CNT_W-1:0] split_cnt_o
);

  typedef enum logic [0:0] {StPair, StSplit2} state_e;

  state_e state_q, state_d;
  logic   conflict;
  logic   raw_hit, waw_hit, mem_hit;
  logic   split_enter;
  logic   cnt_en;

  logic [CNT_W-1:0] pair_cnt_q, single_cnt_q, split_cnt_q;

  // Slot-1 sources never matter: WAR within a pair is safe since operands are read in decode.
  logic unused_slot1_srcs;
  assign unused_slot1_srcs = ^{rs1_1_i, rs2_1_i};

  assign raw_hit  = regwrite1_i && (rd1_i != 5'd0) && ((rd1_i == rs1_2_i) || (rd1_i == rs2_2_i));
  assign waw_hit  = regwrite1_i && regwrite2_i && (rd1_i != 5'd0) && (rd1_i == rd2_i);
  assign mem_hit  = mem1_i && mem2_i;
  assign conflict = valid1_i && valid2_i && (raw_hit || waw_hit || mem_hit);

  always_comb begin
    state_d     = state_q;
    issue1_o    = 1'b0;
    issue2_o    = 1'b0;
    hold_fd_o   = 1'b0;
    split_enter = 1'b0;
    if (reset) begin
      case (state_q)
        StPair: begin
          if (flush_i) begin
            state_d = StPair;
          end else if (stall_i) begin
            hold_fd_o = 1'b1;
          end else if (conflict) begin
            issue1_o    = 1'b1;
            hold_fd_o   = 1'b1;
            split_enter = 1'b1;
            state_d     = StSplit2;
          end else begin
            issue1_o = valid1_i;
            issue2_o = valid2_i;
          end
        end
        StSplit2: begin
          if (flush_i) begin
            state_d = StPair;
          end else if (stall_i) begin
            hold_fd_o = 1'b1;
          end else begin
            issue2_o = 1'b1;
            state_d  = StPair;
          end
        end
        default: state_d = StPair;
      endcase
    end
  end

  assign cnt_en = !flush_i && !stall_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StPair;
      pair_cnt_q   <= '0;
      single_cnt_q <= '0;
      split_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_en) begin
        if (issue1_o && issue2_o && !(&pair_cnt_q)) begin
          pair_cnt_q <= pair_cnt_q + CNT_W'(1);
        end
        if ((issue1_o ^ issue2_o) && !(&single_cnt_q)) begin
          single_cnt_q <= single_cnt_q + CNT_W'(1);
        end
        if (split_enter && !(&split_cnt_q)) begin
          split_cnt_q <= split_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign split_o      = (state_q == StSplit2);
  assign pair_cnt_o   = pair_cnt_q;
  assign single_cnt_o = single_cnt_q;
  assign split_cnt_o  = split_cnt_q;

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Self-checking bench: directed literal cases plus randomized traffic compared every cycle
// against a behavioural model, on a 32-bit and a 4-bit counter instance.
module tb_dual_issue_scheduler;

  logic clk = 1'b0;
  logic reset;
  logic valid1, valid2;
  logic [4:0] rd1, rs11, rs21, rd2, rs12, rs22;
  logic rw1, rw2, mem1, mem2, stall, flush;

  logic a_i1, a_i2, a_hold, a_split;
  logic [31:0] a_pair, a_single, a_splitc;
  logic b_i1, b_i2, b_hold, b_split;
  logic [3:0] b_pair, b_single, b_splitc;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  // Model state: has slot 1 of the pair in decode already left?
  bit     m_slot1_gone = 1'b0;
  longint m_pair = 0, m_single = 0, m_splitc = 0;
  longint m4_pair = 0, m4_single = 0, m4_splitc = 0;

  always #5 clk = ~clk;

  dual_issue_scheduler #(.CNT_W(32)) dut32 (
    .clk(clk), .reset(reset), .valid1_i(valid1), .valid2_i(valid2),
    .rd1_i(rd1), .rs1_1_i(rs11), .rs2_1_i(rs21), .rd2_i(rd2), .rs1_2_i(rs12), .rs2_2_i(rs22),
    .regwrite1_i(rw1), .regwrite2_i(rw2), .mem1_i(mem1), .mem2_i(mem2),
    .stall_i(stall), .flush_i(flush), .issue1_o(a_i1), .issue2_o(a_i2), .hold_fd_o(a_hold),
    .split_o(a_split), .pair_cnt_o(a_pair), .single_cnt_o(a_single), .split_cnt_o(a_splitc)
  );

  dual_issue_scheduler #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .valid1_i(valid1), .valid2_i(valid2),
    .rd1_i(rd1), .rs1_1_i(rs11), .rs2_1_i(rs21), .rd2_i(rd2), .rs1_2_i(rs12), .rs2_2_i(rs22),
    .regwrite1_i(rw1), .regwrite2_i(rw2), .mem1_i(mem1), .mem2_i(mem2),
    .stall_i(stall), .flush_i(flush), .issue1_o(b_i1), .issue2_o(b_i2), .hold_fd_o(b_hold),
    .split_o(b_split), .pair_cnt_o(b_pair), .single_cnt_o(b_single), .split_cnt_o(b_splitc)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    bit i1;
    bit i2;
    bit hold;
    bit enter;
    bit gone_next;
  } exp_t;

  function automatic bit pair_conflicts();
    bit raw, waw, st;
    raw = rw1 && rd1 != 0 && (rd1 == rs12 || rd1 == rs22);
    waw = rw1 && rw2 && rd1 != 0 && rd1 == rd2;
    st  = mem1 && mem2;
    return valid1 && valid2 && (raw || waw || st);
  endfunction

  function automatic exp_t model_eval();
    exp_t e = '0;
    e.gone_next = m_slot1_gone;
    if (flush) begin
      e.gone_next = 1'b0;
    end else if (stall) begin
      e.hold = 1'b1;
    end else if (m_slot1_gone) begin
      e.i2 = 1'b1;
      e.gone_next = 1'b0;
    end else if (pair_conflicts()) begin
      e.i1 = 1'b1;
      e.hold = 1'b1;
      e.enter = 1'b1;
      e.gone_next = 1'b1;
    end else begin
      e.i1 = valid1;
      e.i2 = valid2;
    end
    return e;
  endfunction

  function automatic longint sat_inc(input longint v, input longint maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    started <= 1'b1;
    if (!reset) begin
      m_slot1_gone = 1'b0;
      m_pair = 0; m_single = 0; m_splitc = 0;
      m4_pair = 0; m4_single = 0; m4_splitc = 0;
    end else begin
      e = model_eval();
      if (!flush && !stall) begin
        if (e.i1 && e.i2) begin
          m_pair  = sat_inc(m_pair, 64'hFFFF_FFFF);
          m4_pair = sat_inc(m4_pair, 15);
        end
        if (e.i1 != e.i2) begin
          m_single  = sat_inc(m_single, 64'hFFFF_FFFF);
          m4_single = sat_inc(m4_single, 15);
        end
        if (e.enter) begin
          m_splitc  = sat_inc(m_splitc, 64'hFFFF_FFFF);
          m4_splitc = sat_inc(m4_splitc, 15);
        end
      end
      m_slot1_gone = e.gone_next;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (!reset) begin
        chk("rst_issue1", a_i1, 0);
        chk("rst_issue2", a_i2, 0);
        chk("rst_issue1_w4", b_i1, 0);
        chk("rst_issue2_w4", b_i2, 0);
      end else begin
        e = model_eval();
        chk("issue1", a_i1, e.i1);
        chk("issue2", a_i2, e.i2);
        chk("hold", a_hold, e.hold);
        chk("issue1_w4", b_i1, e.i1);
        chk("issue2_w4", b_i2, e.i2);
        chk("hold_w4", b_hold, e.hold);
      end
      chk("split_o", a_split, m_slot1_gone);
      chk("split_o_w4", b_split, m_slot1_gone);
      chk("pair_cnt", a_pair, m_pair);
      chk("single_cnt", a_single, m_single);
      chk("split_cnt", a_splitc, m_splitc);
      chk("pair_cnt_w4", b_pair, m4_pair);
      chk("single_cnt_w4", b_single, m4_single);
      chk("split_cnt_w4", b_splitc, m4_splitc);
    end
  end

  task automatic idle();
    valid1 = 0; valid2 = 0; rd1 = 0; rs11 = 0; rs21 = 0; rd2 = 0; rs12 = 0; rs22 = 0;
    rw1 = 0; rw2 = 0; mem1 = 0; mem2 = 0; stall = 0; flush = 0;
  endtask

  task automatic set_pair(input logic [4:0] d1, input logic [4:0] a1, input logic [4:0] b1,
                          input logic [4:0] d2, input logic [4:0] a2, input logic [4:0] b2,
                          input logic m1, input logic m2);
    valid1 = 1; valid2 = 1; rd1 = d1; rs11 = a1; rs21 = b1; rd2 = d2; rs12 = a2; rs22 = b2;
    rw1 = 1; rw2 = 1; mem1 = m1; mem2 = m2; stall = 0; flush = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk("lit_reset_split", a_split, 0);
    chk("lit_reset_pair", a_pair, 0);

    // Independent pair dual-issues.
    set_pair(5, 6, 7, 8, 9, 10, 0, 0);
    #2;
    chk("lit_indep_i1", a_i1, 1);
    chk("lit_indep_i2", a_i2, 1);
    chk("lit_indep_hold", a_hold, 0);
    next(); idle();
    chk("lit_indep_pair", a_pair, 1);
    chk("lit_indep_split", a_splitc, 0);

    // RAW pair splits over two cycles.
    set_pair(5, 6, 7, 8, 5, 10, 0, 0);
    #2;
    chk("lit_raw_i1", a_i1, 1);
    chk("lit_raw_i2", a_i2, 0);
    chk("lit_raw_hold", a_hold, 1);
    next();
    chk("lit_raw_split_o", a_split, 1);
    #2;
    chk("lit_raw_n1_i1", a_i1, 0);
    chk("lit_raw_n1_i2", a_i2, 1);
    chk("lit_raw_n1_hold", a_hold, 0);
    next(); idle();
    chk("lit_raw_splitcnt", a_splitc, 1);
    chk("lit_raw_single", a_single, 2);

    // x0 destination never conflicts.
    set_pair(0, 6, 7, 8, 0, 10, 0, 0);
    #2;
    chk("lit_x0_i2", a_i2, 1);

    // Two memory ops split; stall three cycles in SPLIT2.
    next(); set_pair(5, 6, 7, 8, 9, 10, 1, 1);
    #2;
    chk("lit_mem_i2", a_i2, 0);
    chk("lit_mem_hold", a_hold, 1);
    next();
    chk("lit_mem_split_o", a_split, 1);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("lit_stall_i2", a_i2, 0);
      chk("lit_stall_hold", a_hold, 1);
      next();
    end
    stall = 0;
    #2;
    chk("lit_after_stall_i2", a_i2, 1);
    chk("lit_after_stall_hold", a_hold, 0);
    next(); idle();
    chk("lit_stall_splitcnt", a_splitc, 2);
    chk("lit_stall_split_o", a_split, 0);

    // Flush in SPLIT2 abandons issue2.
    set_pair(5, 6, 7, 8, 9, 10, 1, 1);
    next(); flush = 1;
    #2;
    chk("lit_flush_split_i2", a_i2, 0);
    chk("lit_flush_split_hold", a_hold, 0);
    next(); idle();
    chk("lit_flush_split_o", a_split, 0);

    // Flush beats a conflicting pair in PAIR.
    set_pair(5, 6, 7, 5, 9, 10, 0, 0);
    flush = 1;
    #2;
    chk("lit_flush_conf_i1", a_i1, 0);
    chk("lit_flush_conf_i2", a_i2, 0);
    next(); idle();
    chk("lit_flush_conf_split_o", a_split, 0);
    chk("lit_flush_conf_splitcnt", a_splitc, 3);

    // Saturation of the 4-bit counters.
    reset = 0; next(); reset = 1;
    for (int i = 0; i < 20; i++) begin
      set_pair(5, 6, 7, 8, 9, 10, 0, 0);
      next();
    end
    idle();
    chk("lit_sat_pair_w4", b_pair, 15);
    chk("lit_sat_pair_w32", a_pair, 20);
    reset = 0; next(); reset = 1;
    chk("lit_rst_pair_w4", b_pair, 0);
    chk("lit_rst_single_w4", b_single, 0);
    chk("lit_rst_split_w4", b_splitc, 0);
    chk("lit_rst_split_o", b_split, 0);

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      valid1 = ($urandom_range(0, 99) < 85);
      valid2 = ($urandom_range(0, 99) < 85);
      rd1 = 5'($urandom_range(0, 3)); rs11 = 5'($urandom_range(0, 3));
      rs21 = 5'($urandom_range(0, 3)); rd2 = 5'($urandom_range(0, 3));
      rs12 = 5'($urandom_range(0, 3)); rs22 = 5'($urandom_range(0, 3));
      rw1 = 1'($urandom_range(0, 1)); rw2 = 1'($urandom_range(0, 1));
      mem1 = ($urandom_range(0, 99) < 30); mem2 = ($urandom_range(0, 99) < 30);
      stall = ($urandom_range(0, 99) < 12);
      flush = ($urandom_range(0, 99) < 5);
      reset = !($urandom_range(0, 199) == 0);
      next();
    end
    idle();
    reset = 1;
    next();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
